// File: rtl/stream_downsizer.sv
// Ready/valid width converter: splits each IN_W-bit word into IN_W/OUT_W beats,
// least-significant beat first, with zero-bubble reload on the last beat.
//
// state | meaning
// EMPTY | no word held; in_ready follows reset only
// SEND  | word in flight; data_q[OUT_W-1:0] is the current beat
module stream_downsizer #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last
);

    localparam int RATIO = IN_W / OUT_W;
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RATIO - 1);

    if ((IN_W % OUT_W) != 0 || RATIO < 2) begin : g_bad_params
        $error("stream_downsizer: IN_W must be a multiple of OUT_W with ratio >= 2");
    end

    typedef enum logic {
        EMPTY = 1'b0,
        SEND  = 1'b1
    } state_t;

    state_t           state_q;
    logic [IN_W-1:0]  data_q;
    logic [CNT_W-1:0] cnt;
    logic             full;
    logic             accept_in;
    logic             accept_out;

    assign full       = (state_q == SEND);
    assign out_valid  = full;
    assign out_data   = data_q[OUT_W-1:0];
    assign out_last   = full && (cnt == LAST_IDX);
    // out_ready -> in_ready is combinational so a new word can load as the last beat leaves
    assign in_ready   = !rst && (!full || (out_ready && out_last));
    assign accept_in  = in_valid && in_ready;
    assign accept_out = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            cnt     <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept_in) begin
                        data_q  <= in_data;
                        cnt     <= '0;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (accept_out) begin
                        if (!out_last) begin
                            data_q <= data_q >> OUT_W;
                            cnt    <= cnt + 1'b1;
                        end else if (accept_in) begin
                            data_q <= in_data;
                            cnt    <= '0;
                        end else begin
                            cnt     <= '0;
                            state_q <= EMPTY;
                        end
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    cnt     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_downsizer.sv
// Scoreboard bench for stream_downsizer (32 -> 8): stimulus pushes expected beats,
// a negedge monitor pops and compares every accepted output beat.
module tb_stream_downsizer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;

    int n_cmp = 0;
    int n_bad = 0;
    logic [8:0] sb[$];   // {last, data}

    stream_downsizer #(.IN_W(32), .OUT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        logic [31:0] tmp;
        tmp = w;
        for (int i = 0; i < 4; i++) begin
            sb.push_back({(i == 3) ? 1'b1 : 1'b0, tmp[7:0]});
            tmp = tmp >> 8;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every beat accepted downstream must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", {23'd0, out_last, out_data}, 32'h1ff);
            end else begin
                logic [8:0] e;
                e = sb.pop_front();
                chk("beat_data", {24'd0, out_data}, {24'd0, e[7:0]});
                chk("beat_last", {31'd0, out_last}, {31'd0, e[8]});
            end
        end
    end

    initial begin
        logic [7:0] bp_data [7];
        logic       bp_last [7];
        logic       bp_rdy  [7];
        bp_data = '{8'h11, 8'h22, 8'h22, 8'h22, 8'h33, 8'h44, 8'h44};
        bp_last = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        bp_rdy  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset with in_valid high: nothing may be captured.
        rst = 1'b1; in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b1;
        @(negedge clk);
        chk("rst_in_ready_c1", {31'd0, in_ready}, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("rst_in_ready_c2", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        next_cycle();
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

        // Single word.
        next_cycle();
        in_valid = 1'b1; in_data = 32'hDDCCBBAA; out_ready = 1'b1;
        push_word(32'hDDCCBBAA);
        @(negedge clk);
        chk("single_load_ready", {31'd0, in_ready}, 32'd1);
        next_cycle();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("single_valid", {31'd0, out_valid}, 32'd1);
            chk("single_in_ready", {31'd0, in_ready}, {31'd0, (k == 3)});
            next_cycle();
        end
        @(negedge clk);
        chk("single_idle", {31'd0, out_valid}, 32'd0);
        chk("single_sb_empty", sb.size(), 32'd0);

        // Back-to-back words, no bubble.
        next_cycle();
        in_valid = 1'b1; in_data = 32'h03020100;
        push_word(32'h03020100);
        push_word(32'h07060504);
        next_cycle();
        in_data = 32'h07060504;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("b2b_valid", {31'd0, out_valid}, 32'd1);
            chk("b2b_data", {24'd0, out_data}, k);
            chk("b2b_in_ready", {31'd0, in_ready}, {31'd0, (k == 3 || k == 7)});
            next_cycle();
            if (k == 3) in_valid = 1'b0;
        end
        @(negedge clk);
        chk("b2b_idle", {31'd0, out_valid}, 32'd0);
        chk("b2b_sb_empty", sb.size(), 32'd0);

        // Backpressure mid-word and on the last beat.
        next_cycle();
        in_valid = 1'b1; in_data = 32'h44332211;
        push_word(32'h44332211);
        next_cycle();
        in_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            out_ready = bp_rdy[k];
            @(negedge clk);
            chk("bp_data", {24'd0, out_data}, {24'd0, bp_data[k]});
            chk("bp_last", {31'd0, out_last}, {31'd0, bp_last[k]});
            next_cycle();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_idle", {31'd0, out_valid}, 32'd0);
        chk("bp_sb_empty", sb.size(), 32'd0);

        // Last-beat stall with a pending upstream word.
        next_cycle();
        in_valid = 1'b1; in_data = 32'hA0A1A2A3;
        push_word(32'hA0A1A2A3);
        push_word(32'hB0B1B2B3);
        next_cycle();
        in_data = 32'hB0B1B2B3;
        for (int k = 0; k < 3; k++) next_cycle();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_data", {24'd0, out_data}, 32'hA0);
            next_cycle();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall_release_ready", {31'd0, in_ready}, 32'd1);
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        chk("stall_next_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_next_data", {24'd0, out_data}, 32'hB3);
        for (int k = 0; k < 4; k++) next_cycle();
        @(negedge clk);
        chk("stall_idle", {31'd0, out_valid}, 32'd0);
        chk("stall_sb_empty", sb.size(), 32'd0);

        // Mid-word reset discards the remaining beats.
        next_cycle();
        in_valid = 1'b1; in_data = 32'h88776655;
        push_word(32'h88776655);
        next_cycle();
        in_valid = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("mid_rst_pending", sb.size(), 32'd2);
        next_cycle();
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_data", {24'd0, out_data}, 32'd0);
        next_cycle();
        in_valid = 1'b1; in_data = 32'h0D0C0B0A;
        push_word(32'h0D0C0B0A);
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_first", {24'd0, out_data}, 32'h0A);
        chk("mid_rst_first_last", {31'd0, out_last}, 32'd0);
        for (int k = 0; k < 4; k++) next_cycle();
        @(negedge clk);
        chk("mid_rst_idle", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_sb_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
